// File: rtl/arq_tx_ctrl.sv
// -----------------------------------------------------------------------------
// arq_tx_ctrl
// Transmit-side ARQ controller. Counts frames sent but not yet acknowledged,
// blocks new payload mapping when the window is full or a replay is active,
// and triggers replay of the outstanding frames on NACK or ACK timeout. After
// MAX_RETRY consecutive replays without an ACK the link is declared failed.
//
// Ports
//   i_clk               clock, all state on the rising edge
//   i_rst_n             asynchronous active-low reset
//   i_arq_en            ARQ enable; low forces IDLE with everything cleared
//   i_frame_fas         pulse: first byte of a frame left the mapper
//   i_ack               pulse: oldest outstanding frame received good
//   i_nack              pulse: oldest outstanding frame failed CRC
//   i_replay_done       pulse: record FIFO finished replaying
//   o_line_retrans_req  high blocks new payload mapping
//   o_replay_start      one-cycle pulse that starts a replay
//   o_outstanding       number of unacknowledged frames
//   o_window_full       o_outstanding >= WINDOW
//   o_retry_cnt         consecutive replays since the last ACK
//   o_link_fail         sticky link-failure flag
// -----------------------------------------------------------------------------
module arq_tx_ctrl #(
   parameter int unsigned WINDOW      = 4,
   parameter int unsigned TIMEOUT_CYC = 16384,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_arq_en,
   input  logic       i_frame_fas,
   input  logic       i_ack,
   input  logic       i_nack,
   input  logic       i_replay_done,
   output logic       o_line_retrans_req,
   output logic       o_replay_start,
   output logic [3:0] o_outstanding,
   output logic       o_window_full,
   output logic [3:0] o_retry_cnt,
   output logic       o_link_fail
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_REPLAY_REQ,
      S_REPLAY,
      S_FAIL
   } state_e;

   localparam logic [3:0]  WINDOW_C     = 4'(WINDOW);
   localparam logic [3:0]  MAX_RETRY_C  = 4'(MAX_RETRY);
   localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYC - 1);

   state_e      state_q, state_d;
   logic [3:0]  outstanding_q, outstanding_d;
   logic [3:0]  retry_q, retry_d;
   logic [19:0] timer_q, timer_d;
   logic        window_full_q, window_full_d;
   logic        retrans_q, retrans_d;
   logic        replay_start_q, replay_start_d;
   logic        link_fail_q, link_fail_d;

   logic has_out;
   logic ack_ok;
   logic timeout;
   logic sat;

   assign has_out = (outstanding_q != 4'd0);
   assign ack_ok  = i_ack && has_out;        // ACK with nothing outstanding is dropped
   assign sat     = (outstanding_q == 4'd15);
   // An ACK landing on the expiry cycle means the frame made it; no replay.
   assign timeout = has_out && (timer_q == TIMEOUT_LAST) && !i_ack;

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d       = state_q;
      outstanding_d = outstanding_q;
      retry_d       = retry_q;
      timer_d       = '0;

      case (state_q)
         S_IDLE: begin
            if (i_arq_en) state_d = S_RUN;
         end

         S_RUN: begin
            if ((i_nack && has_out) || timeout) begin
               // NACK wins over a same-cycle ACK; a new frame still counts.
               if (retry_q == MAX_RETRY_C) begin
                  state_d = S_FAIL;
               end else begin
                  state_d = S_REPLAY_REQ;
                  retry_d = retry_q + 4'd1;
               end
               if (i_frame_fas && !sat) outstanding_d = outstanding_q + 4'd1;
            end else begin
               case ({i_frame_fas, ack_ok})
                  2'b10:   if (!sat) outstanding_d = outstanding_q + 4'd1;
                  2'b01:   outstanding_d = outstanding_q - 4'd1;
                  default: outstanding_d = outstanding_q;
               endcase
               if (ack_ok) retry_d = '0;
               // Timer runs only while something is in flight and unacknowledged.
               if (has_out && !ack_ok) timer_d = timer_q + 20'd1;
            end
         end

         S_REPLAY_REQ, S_REPLAY: begin
            // Frames leaving the mapper here are replays, not new frames.
            if (ack_ok) begin
               outstanding_d = outstanding_q - 4'd1;
               retry_d       = '0;
            end
            if (state_q == S_REPLAY_REQ) state_d = S_REPLAY;
            else if (i_replay_done)      state_d = S_RUN;
         end

         S_FAIL: begin
            state_d = S_FAIL;
         end

         default: state_d = S_IDLE;
      endcase

      if (!i_arq_en) begin
         state_d       = S_IDLE;
         outstanding_d = '0;
         retry_d       = '0;
         timer_d       = '0;
      end

      window_full_d  = (outstanding_d >= WINDOW_C);
      retrans_d      = window_full_d ||
                       (state_d inside {S_REPLAY_REQ, S_REPLAY, S_FAIL});
      replay_start_d = (state_d == S_REPLAY_REQ);
      link_fail_d    = (state_d == S_FAIL);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= S_IDLE;
         outstanding_q  <= '0;
         retry_q        <= '0;
         timer_q        <= '0;
         window_full_q  <= 1'b0;
         retrans_q      <= 1'b0;
         replay_start_q <= 1'b0;
         link_fail_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         outstanding_q  <= outstanding_d;
         retry_q        <= retry_d;
         timer_q        <= timer_d;
         window_full_q  <= window_full_d;
         retrans_q      <= retrans_d;
         replay_start_q <= replay_start_d;
         link_fail_q    <= link_fail_d;
      end
   end

   assign o_line_retrans_req = retrans_q;
   assign o_replay_start     = replay_start_q;
   assign o_outstanding      = outstanding_q;
   assign o_window_full      = window_full_q;
   assign o_retry_cnt        = retry_q;
   assign o_link_fail        = link_fail_q;

endmodule

// File: tb/tb_arq_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arq_tx_ctrl
// Directed bench for arq_tx_ctrl with WINDOW=4, TIMEOUT_CYC=32, MAX_RETRY=3.
// Inputs change 1 ns after a rising edge and outputs are read at that point,
// so each value seen reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_arq_tx_ctrl;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b1;
   logic       arq_en   = 1'b0;
   logic       fas      = 1'b0;
   logic       ack      = 1'b0;
   logic       nack     = 1'b0;
   logic       done     = 1'b0;
   logic       retrans;
   logic       replay_start;
   logic [3:0] outstanding;
   logic       window_full;
   logic [3:0] retry_cnt;
   logic       link_fail;

   int n_pass  = 0;
   int n_total = 0;

   arq_tx_ctrl #(
      .WINDOW      (4),
      .TIMEOUT_CYC (32),
      .MAX_RETRY   (3)
   ) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_arq_en           (arq_en),
      .i_frame_fas        (fas),
      .i_ack              (ack),
      .i_nack             (nack),
      .i_replay_done      (done),
      .o_line_retrans_req (retrans),
      .o_replay_start     (replay_start),
      .o_outstanding      (outstanding),
      .o_window_full      (window_full),
      .o_retry_cnt        (retry_cnt),
      .o_link_fail        (link_fail)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   function automatic logic [11:0] all_outs();
      return {retrans, replay_start, outstanding, window_full, retry_cnt, link_fail};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic f, input logic a, input logic n, input logic d);
      fas  = f;
      ack  = a;
      nack = n;
      done = d;
      tick();
      fas  = 1'b0;
      ack  = 1'b0;
      nack = 1'b0;
      done = 1'b0;
   endtask

   // Clear the block through IDLE and enter RUN.
   task automatic start_run();
      arq_en = 1'b0;
      tick();
      arq_en = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #2;
      n_total++; if (all_outs() !== 12'h000) $display("FAIL reset_outs got %h want 000", all_outs()); else n_pass++;
      tick();
      tick();
      #3 rst_n = 1'b1;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      n_total++; if (outstanding !== 4'd0) $display("FAIL idle_no_count got %0d want 0", outstanding); else n_pass++;
      n_total++; if (all_outs() !== 12'h000) $display("FAIL idle_outs got %h want 000", all_outs()); else n_pass++;
   endtask

   task automatic test_window();
      start_run();
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
      n_total++; if (outstanding !== 4'd3) $display("FAIL win_cnt3 got %0d want 3", outstanding); else n_pass++;
      n_total++; if (window_full !== 1'b0) $display("FAIL win_full3 got %b want 0", window_full); else n_pass++;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      n_total++; if (outstanding !== 4'd4) $display("FAIL win_cnt4 got %0d want 4", outstanding); else n_pass++;
      n_total++; if (window_full !== 1'b1) $display("FAIL win_full4 got %b want 1", window_full); else n_pass++;
      n_total++; if (retrans !== 1'b1) $display("FAIL win_retrans4 got %b want 1", retrans); else n_pass++;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      n_total++; if (outstanding !== 4'd3) $display("FAIL win_ack_cnt got %0d want 3", outstanding); else n_pass++;
      n_total++; if ({window_full, retrans} !== 2'b00) $display("FAIL win_ack_flags got %b want 00", {window_full, retrans}); else n_pass++;
      // 3 + 13 frames would be 16; the count saturates at 15.
      for (int i = 0; i < 13; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
      n_total++; if (outstanding !== 4'd15) $display("FAIL win_sat got %0d want 15", outstanding); else n_pass++;
   endtask

   task automatic test_nack_replay();
      start_run();
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      n_total++; if ({replay_start, retrans} !== 2'b11) $display("FAIL nack_start got %b want 11", {replay_start, retrans}); else n_pass++;
      n_total++; if (retry_cnt !== 4'd1) $display("FAIL nack_retry got %0d want 1", retry_cnt); else n_pass++;
      tick();
      n_total++; if ({replay_start, retrans} !== 2'b01) $display("FAIL nack_replay got %b want 01", {replay_start, retrans}); else n_pass++;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      n_total++; if (outstanding !== 4'd2) $display("FAIL replay_fas got %0d want 2", outstanding); else n_pass++;
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      n_total++; if ({replay_start, retry_cnt} !== 5'b0_0001) $display("FAIL replay_nack got %b want 00001", {replay_start, retry_cnt}); else n_pass++;
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      n_total++; if (retrans !== 1'b0) $display("FAIL replay_done_retrans got %b want 0", retrans); else n_pass++;
      n_total++; if (outstanding !== 4'd2) $display("FAIL replay_done_cnt got %0d want 2", outstanding); else n_pass++;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      n_total++; if ({outstanding, retry_cnt} !== 8'h10) $display("FAIL ack_clears_retry got %h want 10", {outstanding, retry_cnt}); else n_pass++;
   endtask

   task automatic test_timeout();
      int first;
      bit seen;
      start_run();
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      first = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (replay_start && first == 0) first = i;
      end
      n_total++; if (first !== 32) $display("FAIL timeout_latency got %0d want 32", first); else n_pass++;
      n_total++; if ({retrans, retry_cnt} !== 5'b1_0001) $display("FAIL timeout_state got %b want 10001", {retrans, retry_cnt}); else n_pass++;

      start_run();
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (19) tick();
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (replay_start) seen = 1'b1;
      end
      n_total++; if (seen !== 1'b0) $display("FAIL timeout_acked got replay %b want 0", seen); else n_pass++;
      n_total++; if (outstanding !== 4'd0) $display("FAIL timeout_acked_cnt got %0d want 0", outstanding); else n_pass++;
   endtask

   task automatic test_max_retry();
      start_run();
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         pulse(1'b0, 1'b0, 1'b1, 1'b0);
         n_total++; if ({replay_start, retry_cnt} !== {1'b1, 4'(i)}) $display("FAIL retry_%0d got %b want %b", i, {replay_start, retry_cnt}, {1'b1, 4'(i)}); else n_pass++;
         tick();
         pulse(1'b0, 1'b0, 1'b0, 1'b1);
      end
      n_total++; if (link_fail !== 1'b0) $display("FAIL fail_early got %b want 0", link_fail); else n_pass++;
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      n_total++; if ({link_fail, retrans, replay_start} !== 3'b110) $display("FAIL fail_flags got %b want 110", {link_fail, retrans, replay_start}); else n_pass++;
      n_total++; if (retry_cnt !== 4'd3) $display("FAIL fail_retry got %0d want 3", retry_cnt); else n_pass++;
      pulse(1'b1, 1'b1, 1'b1, 1'b1);
      n_total++; if ({link_fail, outstanding} !== 5'b1_0001) $display("FAIL fail_ignores got %b want 10001", {link_fail, outstanding}); else n_pass++;
      arq_en = 1'b0;
      tick();
      n_total++; if (all_outs() !== 12'h000) $display("FAIL fail_disable got %h want 000", all_outs()); else n_pass++;
   endtask

   task automatic test_simultaneous();
      start_run();
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b1, 1'b0);
      n_total++; if ({outstanding, replay_start} !== 5'b0001_1) $display("FAIL acknack got %b want 00011", {outstanding, replay_start}); else n_pass++;
      tick();
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      n_total++; if (outstanding !== 4'd1) $display("FAIL fas_ack got %0d want 1", outstanding); else n_pass++;
      n_total++; if (retry_cnt !== 4'd0) $display("FAIL fas_ack_retry got %0d want 0", retry_cnt); else n_pass++;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      n_total++; if (outstanding !== 4'd0) $display("FAIL ack_at_zero got %0d want 0", outstanding); else n_pass++;
   endtask

   task automatic test_reset_mid_replay();
      start_run();
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      n_total++; if (retrans !== 1'b1) $display("FAIL pre_reset_retrans got %b want 1", retrans); else n_pass++;
      #3 rst_n = 1'b0;
      #1;
      n_total++; if (all_outs() !== 12'h000) $display("FAIL async_reset got %h want 000", all_outs()); else n_pass++;
      fas = 1'b1;
      #2 rst_n = 1'b1;
      // First edge after release sees arq_en=1: IDLE->RUN, the frame is not counted.
      tick();
      n_total++; if (outstanding !== 4'd0) $display("FAIL post_reset_idle got %0d want 0", outstanding); else n_pass++;
      tick();
      fas = 1'b0;
      n_total++; if (outstanding !== 4'd1) $display("FAIL post_reset_run got %0d want 1", outstanding); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_window();
      test_nack_replay();
      test_timeout();
      test_max_retry();
      test_simultaneous();
      test_reset_mid_replay();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
